// File: rtl/vga_frame_reader.sv
// VGA scan-out engine for the 25 MHz pixel domain.
// Generates VGA timing, fetches pixels from the frame-buffer BRAM with
// optional 2^SCALE_SHIFT integer upscaling, and compensates a BRAM read
// latency of RD_LAT cycles. All o_VGA_* outputs lag the internal timing
// counters by RD_LAT+1 cycles and are mutually aligned.
//
// Ports:
//   i_clk25m, i_rstn_clk25m : pixel clock, async active-low reset
//   i_enable                : scan-out enable, sampled at frame end
//   i_mode                  : 0 gray, 1 RGB444, 2 colour bars, 3 black (frame end)
//   o_pix_addr, o_pix_rd_en : BRAM read request
//   i_pix_data              : BRAM data, RD_LAT cycles after the address
//   o_VGA_*                 : aligned position, sync, video flag and colour
//   o_frame_start           : pulse with output pixel (0,0)
//
// state  | meaning
// IDLE   | no reads, timing free-running
// SKIP   | discarding SKIP_FRAMES complete frames
// STREAM | reading pixels from the frame buffer
module vga_frame_reader #(
    parameter int H_DISP      = 640,
    parameter int H_FP        = 16,
    parameter int H_PULSE     = 96,
    parameter int H_BP        = 48,
    parameter int V_DISP      = 480,
    parameter int V_FP        = 10,
    parameter int V_PULSE     = 2,
    parameter int V_BP        = 33,
    parameter int SCALE_SHIFT = 0,
    parameter int SKIP_FRAMES = 2,
    parameter int RD_LAT      = 1,
    parameter int ADDR_W      = 19,
    parameter int PIX_W       = 12
) (
    input  logic              i_clk25m,
    input  logic              i_rstn_clk25m,
    input  logic              i_enable,
    input  logic [1:0]        i_mode,
    output logic [ADDR_W-1:0] o_pix_addr,
    output logic              o_pix_rd_en,
    input  logic [PIX_W-1:0]  i_pix_data,
    output logic [9:0]        o_VGA_x,
    output logic [9:0]        o_VGA_y,
    output logic              o_VGA_hsync,
    output logic              o_VGA_vsync,
    output logic              o_VGA_video,
    output logic [3:0]        o_VGA_r,
    output logic [3:0]        o_VGA_g,
    output logic [3:0]        o_VGA_b,
    output logic              o_frame_start
);

    localparam int H_TOTAL = H_DISP + H_FP + H_PULSE + H_BP;
    localparam int V_TOTAL = V_DISP + V_FP + V_PULSE + V_BP;
    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_DISP_C = 10'(H_DISP);
    localparam logic [9:0] V_DISP_C = 10'(V_DISP);
    localparam logic [9:0] HS_BEG   = 10'(H_DISP + H_FP);
    localparam logic [9:0] HS_END   = 10'(H_DISP + H_FP + H_PULSE);
    localparam logic [9:0] VS_BEG   = 10'(V_DISP + V_FP);
    localparam logic [9:0] VS_END   = 10'(V_DISP + V_FP + V_PULSE);
    localparam logic [9:0] S_MASK   = 10'((1 << SCALE_SHIFT) - 1);
    localparam logic [ADDR_W-1:0] W_SRC = ADDR_W'(H_DISP >> SCALE_SHIFT);
    localparam logic [9:0] BAR_LD   = 10'(H_DISP / 8 - 1);
    localparam logic [3:0] SKIP_LD  = 4'((SKIP_FRAMES > 0) ? SKIP_FRAMES - 1 : 0);

    typedef enum logic [1:0] {IDLE, SKIP, STREAM} state_t;

    typedef struct packed {
        logic       hs;
        logic       vs;
        logic       video;
        logic [9:0] x;
        logic [9:0] y;
        logic       fs;
        logic       stream;
        logic [1:0] mode;
        logic [2:0] bar;
    } sb_t;

    localparam sb_t SB_IDLE = '{hs: 1'b1, vs: 1'b1, video: 1'b0, x: 10'd0, y: 10'd0,
                                fs: 1'b0, stream: 1'b0, mode: 2'd0, bar: 3'd0};

    state_t            state, state_n;
    logic [9:0]        cx, cy, cx_n, cy_n;
    logic [ADDR_W-1:0] row_base, row_base_n, addr_n;
    logic [9:0]        bar_cnt, bar_cnt_n;
    logic [2:0]        bar_idx, bar_idx_n;
    logic [3:0]        skip_cnt, skip_n;
    logic [1:0]        mode_q, mode_n;
    logic              line_end, frame_end, rd_en_n;
    sb_t               sb0, tail;
    sb_t               pipe [RD_LAT];
    logic [3:0]        r_n, g_n, b_n;

    // Next-position logic; address and rd_en are registered from these so
    // they line up with the counters rather than trailing them.
    always_comb begin
        line_end   = (cx == H_LAST);
        frame_end  = line_end && (cy == V_LAST);
        cx_n       = line_end ? 10'd0 : cx + 10'd1;
        cy_n       = cy;
        if (line_end) cy_n = (cy == V_LAST) ? 10'd0 : cy + 10'd1;
        row_base_n = row_base;
        if (frame_end)
            row_base_n = '0;
        else if (line_end && (cy < V_DISP_C) && ((cy & S_MASK) == S_MASK))
            row_base_n = row_base + W_SRC;
        mode_n     = frame_end ? i_mode : mode_q;
        bar_cnt_n  = bar_cnt - 10'd1;
        bar_idx_n  = bar_idx;
        if (line_end) begin
            bar_cnt_n = BAR_LD;
            bar_idx_n = 3'd0;
        end else if (bar_cnt == 10'd0) begin
            bar_cnt_n = BAR_LD;
            bar_idx_n = bar_idx + 3'd1;
        end
    end

    always_comb begin
        state_n = state;
        skip_n  = skip_cnt;
        if (frame_end) begin
            case (state)
                IDLE: if (i_enable) begin
                    if (SKIP_FRAMES == 0) begin
                        state_n = STREAM;
                    end else begin
                        state_n = SKIP;
                        skip_n  = SKIP_LD;
                    end
                end
                SKIP: begin
                    if (skip_cnt == 4'd0) state_n = STREAM;
                    else                  skip_n  = skip_cnt - 4'd1;
                end
                STREAM: if (!i_enable) state_n = IDLE;
                default: state_n = IDLE;
            endcase
        end
        rd_en_n = (state_n == STREAM) && (cx_n < H_DISP_C) && (cy_n < V_DISP_C) && !mode_n[1];
        addr_n  = rd_en_n ? row_base_n + ADDR_W'(cx_n >> SCALE_SHIFT) : '0;
    end

    always_ff @(posedge i_clk25m or negedge i_rstn_clk25m) begin
        if (!i_rstn_clk25m) begin
            state       <= IDLE;
            cx          <= '0;
            cy          <= '0;
            row_base    <= '0;
            bar_cnt     <= BAR_LD;
            bar_idx     <= '0;
            skip_cnt    <= '0;
            mode_q      <= '0;
            o_pix_addr  <= '0;
            o_pix_rd_en <= 1'b0;
        end else begin
            state       <= state_n;
            cx          <= cx_n;
            cy          <= cy_n;
            row_base    <= row_base_n;
            bar_cnt     <= bar_cnt_n;
            bar_idx     <= bar_idx_n;
            skip_cnt    <= skip_n;
            mode_q      <= mode_n;
            o_pix_addr  <= addr_n;
            o_pix_rd_en <= rd_en_n;
        end
    end

    // Stage-0 sideband; state and mode travel with the pixel so a frame-end
    // change never affects pixels still in flight.
    always_comb begin
        sb0        = SB_IDLE;
        sb0.hs     = !((cx >= HS_BEG) && (cx < HS_END));
        sb0.vs     = !((cy >= VS_BEG) && (cy < VS_END));
        sb0.video  = (cx < H_DISP_C) && (cy < V_DISP_C);
        sb0.x      = cx;
        sb0.y      = cy;
        sb0.fs     = (cx == 10'd0) && (cy == 10'd0);
        sb0.stream = (state == STREAM);
        sb0.mode   = mode_q;
        sb0.bar    = bar_idx;
    end

    always_ff @(posedge i_clk25m or negedge i_rstn_clk25m) begin
        if (!i_rstn_clk25m) begin
            for (int i = 0; i < RD_LAT; i++) pipe[i] <= SB_IDLE;
        end else begin
            pipe[0] <= sb0;
            for (int i = 1; i < RD_LAT; i++) pipe[i] <= pipe[i-1];
        end
    end

    assign tail = pipe[RD_LAT-1];

    always_comb begin
        r_n = 4'd0;
        g_n = 4'd0;
        b_n = 4'd0;
        if (tail.video && tail.stream) begin
            case (tail.mode)
                2'd0: begin
                    r_n = i_pix_data[7:4];
                    g_n = i_pix_data[7:4];
                    b_n = i_pix_data[7:4];
                end
                2'd1: begin
                    r_n = i_pix_data[11:8];
                    g_n = i_pix_data[7:4];
                    b_n = i_pix_data[3:0];
                end
                2'd2: begin
                    r_n = {4{tail.bar[2]}};
                    g_n = {4{tail.bar[1]}};
                    b_n = {4{tail.bar[0]}};
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge i_clk25m or negedge i_rstn_clk25m) begin
        if (!i_rstn_clk25m) begin
            o_VGA_x       <= '0;
            o_VGA_y       <= '0;
            o_VGA_hsync   <= 1'b1;
            o_VGA_vsync   <= 1'b1;
            o_VGA_video   <= 1'b0;
            o_VGA_r       <= '0;
            o_VGA_g       <= '0;
            o_VGA_b       <= '0;
            o_frame_start <= 1'b0;
        end else begin
            o_VGA_x       <= tail.x;
            o_VGA_y       <= tail.y;
            o_VGA_hsync   <= tail.hs;
            o_VGA_vsync   <= tail.vs;
            o_VGA_video   <= tail.video;
            o_VGA_r       <= r_n;
            o_VGA_g       <= g_n;
            o_VGA_b       <= b_n;
            o_frame_start <= tail.fs;
        end
    end

endmodule

// File: doc/vga_frame_reader.md
Name: vga_frame_reader

Overview:
Parametrised VGA scan-out engine for the 25 MHz pixel domain. It generates its own VGA timing and fetches pixels from the frame-buffer BRAM, with optional integer upscaling of a reduced-resolution buffer. It compensates for a configurable BRAM read latency and drives aligned RGB and sync outputs. It replaces the fixed 640x480, grayscale-only, single-latency scan-out path and adds an RGB444 mode and a colour-bar test-pattern mode.

Parameters:
H_DISP, 640, active pixels per line
H_FP, 16, horizontal front porch (pixels)
H_PULSE, 96, hsync pulse width (pixels)
H_BP, 48, horizontal back porch (pixels)
V_DISP, 480, active lines
V_FP, 10, vertical front porch (lines)
V_PULSE, 2, vsync pulse width (lines)
V_BP, 33, vertical back porch (lines)
SCALE_SHIFT, 0, upscale factor 2^SCALE_SHIFT; legal values 0..2; source is (H_DISP>>S)x(V_DISP>>S)
SKIP_FRAMES, 2, complete frames discarded after reset/enable before reading; legal values 0..15
RD_LAT, 1, BRAM read latency in cycles; legal values 1..3
ADDR_W, 19, BRAM address width
PIX_W, 12, BRAM data width

Ports:
i_clk25m  in  1  pixel clock
i_rstn_clk25m  in  1  reset
i_enable  in  1  scan-out enable; sampled only at frame end
i_mode  in  2  0=gray Q4.4, 1=RGB444, 2=colour bars, 3=black; sampled only at frame end
o_pix_addr  out  ADDR_W  BRAM read address
o_pix_rd_en  out  1  BRAM read enable
i_pix_data  in  PIX_W  BRAM read data, valid RD_LAT cycles after address
o_VGA_x  out  10  output-aligned x counter
o_VGA_y  out  10  output-aligned y counter
o_VGA_hsync  out  1  active-low hsync
o_VGA_vsync  out  1  active-low vsync
o_VGA_video  out  1  active-video flag
o_VGA_r  out  4  red
o_VGA_g  out  4  green
o_VGA_b  out  4  blue
o_frame_start  out  1  one-cycle pulse aligned with output pixel (0,0)

Behaviour:
- Interface: reset i_rstn_clk25m, asynchronous, active-low; clock i_clk25m.
- Timing counters:
  - H_TOTAL=H_DISP+H_FP+H_PULSE+H_BP; V_TOTAL likewise for the vertical parameters.
  - Internal stage-0 counters cx in 0..H_TOTAL-1 and cy in 0..V_TOTAL-1. cx wraps to 0; cy increments on the cx wrap.
  - Active region: cx<H_DISP && cy<V_DISP.
  - hsync low for cx in [H_DISP+H_FP, H_DISP+H_FP+H_PULSE). vsync low for cy in the corresponding vertical window.
  - Frame end: cx==H_TOTAL-1 && cy==V_TOTAL-1.
- FSM states:
  - IDLE: rd_en=0.
  - SKIP: counts frame ends.
  - STREAM: reads pixels.
  - Reset enters IDLE.
  - At frame end, IDLE->SKIP if the sampled enable=1. If SKIP_FRAMES==0, go directly to STREAM.
  - SKIP->STREAM at the SKIP_FRAMES-th frame end.
  - STREAM->IDLE at a frame end where enable=0. Deassert mid-frame completes the current frame.
  - Mode register updates only at frame end.
- Address generation (stage 0):
  - W_SRC=H_DISP>>S.
  - o_pix_addr = row_base + (cx>>S), registered so that it is valid with stage-0 position (cx,cy).
  - row_base resets to 0 at frame end.
  - At each active-line end (cx==H_TOTAL-1, cy<V_DISP), row_base += W_SRC only when the low S bits of cy are all 1.
  - o_pix_rd_en=1 only in STREAM, in active region, with mode 0 or 1.
  - Otherwise o_pix_rd_en=0 and o_pix_addr=0.
  - Last address of a frame = W_SRC*(V_DISP>>S)-1; there is no overflow past it.
- Pipeline:
  - hsync, vsync, video, x, y and frame_start are delayed through RD_LAT stages.
  - An output register captures i_pix_data together with the delayed sideband.
  - All o_VGA_* outputs lag stage 0 by exactly RD_LAT+1 cycles and are mutually aligned.
- Colour (output register):
  - Video=0, or any state other than STREAM: rgb=0.
  - Mode 0: r=g=b=i_pix_data[7:4].
  - Mode 1: r=[11:8], g=[7:4], b=[3:0].
  - Mode 2: 8 vertical bars of width H_DISP/8. Bar k (0..7) gives r=g=b of 4'hF selected by bits {k[2],k[1],k[0]} → r/g/b respectively. Pattern is independent of BRAM.
  - Mode 3: rgb=0.
- Reset values:
  - addr=0, rd_en=0, x=y=0, rgb=0, video=0, frame_start=0.
  - hsync=vsync=1.
  - State IDLE, all pipeline stages cleared.
  - Reset mid-frame restarts the counters at (0,0) and re-runs the skip sequence.

Test Plan:
- Reset, enable=1, mode=0, defaults → o_pix_rd_en stays 0 for the first 2×420000+800×525 cycles window through SKIP; first rd_en coincides with stage (0,0) and o_pix_addr=0.
- STREAM, S=0 → addr=639 at (639,0), addr=640 at (0,1), addr=307199 at (639,479), then 0 with rd_en=0 from (640,479) onward.
- SCALE_SHIFT=1 → stage (2,3) gives addr 321; (0,1) gives addr 0; last addr 76799; each address issued 4 times per 2×2 block.
- RD_LAT=3, mode=1, BRAM model returns 12'hF3C at (0,0) → o_VGA_r/g/b=F/3/C exactly 4 cycles after address, same cycle as o_frame_start=1 and o_VGA_video=1.
- Mode 0 with data 12'h0A5 → r=g=b=4'hA; mode switched to 2 mid-frame → change takes effect only after frame end; bar 1 (x=80..159) gives r=0,g=0,b=F.
- hsync low for output x 656..751, vsync low for lines 490..491; enable deasserted at line 100 → frame completes, rd_en=0 from the next frame onward, rgb=0.
